// File: rtl/mc_control_unit.sv
// Multicycle MIPS control FSM: sequences fetch/decode/execute/memory/write-back over a shared
// memory port and single ALU, with memory-ready stalls, illegal-opcode pulse and retire counter.
module mc_control_unit #(
  parameter int OPCODE_W = 6,
  parameter int ALUOP_W  = 3,
  parameter int MEM_WAIT = 1,
  parameter int CNT_W    = 32
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic                mem_ready,
  output logic                PCWrite,
  output logic                PCWriteCond,
  output logic                IorD,
  output logic                IRWrite,
  output logic                MemRead,
  output logic                MemWrite,
  output logic                MemtoReg,
  output logic                RegDst,
  output logic                RegWrite,
  output logic                ALUSrcA,
  output logic [1:0]          ALUSrcB,
  output logic [ALUOP_W-1:0]  ALUOp,
  output logic [1:0]          PCSource,
  output logic                illegal_op,
  output logic [3:0]          state,
  output logic [CNT_W-1:0]    instr_count
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEM_ADDR = 4'd2;
  localparam logic [3:0] S_MEM_RD   = 4'd3;
  localparam logic [3:0] S_MEM_WB   = 4'd4;
  localparam logic [3:0] S_MEM_WR   = 4'd5;
  localparam logic [3:0] S_R_EX     = 4'd6;
  localparam logic [3:0] S_R_WB     = 4'd7;
  localparam logic [3:0] S_I_EX     = 4'd8;
  localparam logic [3:0] S_I_WB     = 4'd9;
  localparam logic [3:0] S_BRANCH   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;

  localparam logic [OPCODE_W-1:0] OP_RTYPE = OPCODE_W'(6'b000000);
  localparam logic [OPCODE_W-1:0] OP_LW    = OPCODE_W'(6'b100011);
  localparam logic [OPCODE_W-1:0] OP_SW    = OPCODE_W'(6'b101011);
  localparam logic [OPCODE_W-1:0] OP_BEQ   = OPCODE_W'(6'b000100);
  localparam logic [OPCODE_W-1:0] OP_J     = OPCODE_W'(6'b000010);
  localparam logic [OPCODE_W-1:0] OP_ADDI  = OPCODE_W'(6'b001000);
  localparam logic [OPCODE_W-1:0] OP_ANDI  = OPCODE_W'(6'b001100);
  localparam logic [OPCODE_W-1:0] OP_ORI   = OPCODE_W'(6'b001101);
  localparam logic [OPCODE_W-1:0] OP_XORI  = OPCODE_W'(6'b001110);
  localparam logic [OPCODE_W-1:0] OP_SLTI  = OPCODE_W'(6'b001010);

  localparam logic [ALUOP_W-1:0] ALU_ADD   = ALUOP_W'(3'b000);
  localparam logic [ALUOP_W-1:0] ALU_SUB   = ALUOP_W'(3'b001);
  localparam logic [ALUOP_W-1:0] ALU_FUNCT = ALUOP_W'(3'b010);
  localparam logic [ALUOP_W-1:0] ALU_AND   = ALUOP_W'(3'b011);
  localparam logic [ALUOP_W-1:0] ALU_OR    = ALUOP_W'(3'b100);
  localparam logic [ALUOP_W-1:0] ALU_XOR   = ALUOP_W'(3'b101);
  localparam logic [ALUOP_W-1:0] ALU_SLT   = ALUOP_W'(3'b110);

  logic [3:0]         state_q, state_d;
  logic [ALUOP_W-1:0] iop_q, iop_d;
  logic               is_sw_q, is_sw_d;
  logic               illegal_d;
  logic               retire;
  logic               mem_ok;

  assign mem_ok = (MEM_WAIT == 0) || mem_ready;
  assign state  = state_q;

  // Next state; I-type ALUOp and lw/sw choice are captured in DECODE so later opcode changes are ignored
  always_comb begin
    state_d   = S_FETCH;
    iop_d     = iop_q;
    is_sw_d   = is_sw_q;
    illegal_d = 1'b0;
    case (state_q)
      S_FETCH:    state_d = mem_ok ? S_DECODE : S_FETCH;
      S_DECODE: begin
        case (opcode)
          OP_RTYPE: state_d = S_R_EX;
          OP_LW:    begin state_d = S_MEM_ADDR; is_sw_d = 1'b0; end
          OP_SW:    begin state_d = S_MEM_ADDR; is_sw_d = 1'b1; end
          OP_BEQ:   state_d = S_BRANCH;
          OP_J:     state_d = S_JUMP;
          OP_ADDI:  begin state_d = S_I_EX; iop_d = ALU_ADD; end
          OP_ANDI:  begin state_d = S_I_EX; iop_d = ALU_AND; end
          OP_ORI:   begin state_d = S_I_EX; iop_d = ALU_OR;  end
          OP_XORI:  begin state_d = S_I_EX; iop_d = ALU_XOR; end
          OP_SLTI:  begin state_d = S_I_EX; iop_d = ALU_SLT; end
          default:  illegal_d = 1'b1;
        endcase
      end
      S_MEM_ADDR: state_d = is_sw_q ? S_MEM_WR : S_MEM_RD;
      S_MEM_RD:   state_d = mem_ok ? S_MEM_WB : S_MEM_RD;
      S_MEM_WB:   state_d = S_FETCH;
      S_MEM_WR:   state_d = mem_ok ? S_FETCH : S_MEM_WR;
      S_R_EX:     state_d = S_R_WB;
      S_R_WB:     state_d = S_FETCH;
      S_I_EX:     state_d = S_I_WB;
      S_I_WB:     state_d = S_FETCH;
      S_BRANCH:   state_d = S_FETCH;
      S_JUMP:     state_d = S_FETCH;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    retire = 1'b0;
    if (state_d == S_FETCH) begin
      case (state_q)
        S_MEM_WB, S_MEM_WR, S_R_WB, S_I_WB, S_BRANCH, S_JUMP: retire = 1'b1;
        default: retire = 1'b0;
      endcase
    end
  end

  always_comb begin
    PCWrite     = 1'b0;
    PCWriteCond = 1'b0;
    IorD        = 1'b0;
    IRWrite     = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    RegDst      = 1'b0;
    RegWrite    = 1'b0;
    ALUSrcA     = 1'b0;
    ALUSrcB     = 2'b00;
    ALUOp       = ALU_ADD;
    PCSource    = 2'b00;
    case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        ALUSrcB = 2'b01;
        PCWrite = mem_ok;
        IRWrite = mem_ok;
      end
      S_DECODE:   ALUSrcB = 2'b11;
      S_MEM_ADDR: begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; end
      S_MEM_RD:   begin MemRead = 1'b1; IorD = 1'b1; end
      S_MEM_WB:   begin RegWrite = 1'b1; MemtoReg = 1'b1; end
      S_MEM_WR:   begin MemWrite = 1'b1; IorD = 1'b1; end
      S_R_EX:     begin ALUSrcA = 1'b1; ALUOp = ALU_FUNCT; end
      S_R_WB:     begin RegWrite = 1'b1; RegDst = 1'b1; end
      S_I_EX:     begin ALUSrcA = 1'b1; ALUSrcB = 2'b10; ALUOp = iop_q; end
      S_I_WB:     RegWrite = 1'b1;
      S_BRANCH: begin
        ALUSrcA     = 1'b1;
        ALUOp       = ALU_SUB;
        PCWriteCond = 1'b1;
        PCSource    = 2'b01;
      end
      S_JUMP:     begin PCWrite = 1'b1; PCSource = 2'b10; end
      default:    ;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_FETCH;
      iop_q       <= ALU_ADD;
      is_sw_q     <= 1'b0;
      illegal_op  <= 1'b0;
      instr_count <= '0;
    end else begin
      state_q    <= state_d;
      iop_q      <= iop_d;
      is_sw_q    <= is_sw_d;
      illegal_op <= illegal_d;
      if (retire) instr_count <= instr_count + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

endmodule

// File: tb/tb_mc_control_unit.sv
// Randomized bench for mc_control_unit: instruction-level path model with random memory stalls,
// plus a MEM_WAIT=0 / narrow-counter instance for the no-handshake flow and counter wrap.
module tb_mc_control_unit;

  localparam int F = 0, D = 1, MA = 2, MR = 3, MWB = 4, MWR = 5;
  localparam int RX = 6, RW = 7, IX = 8, IW = 9, BR = 10, JP = 11;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset_n, reset0_n, mem_ready, mem_ready0;
  logic [5:0] opcode;

  logic        PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst, RegWrite, ALUSrcA;
  logic [1:0]  ALUSrcB, PCSource;
  logic [2:0]  ALUOp;
  logic        illegal_op;
  logic [3:0]  state;
  logic [31:0] instr_count;

  logic        PCWrite0, PCWriteCond0, IorD0, IRWrite0, MemRead0, MemWrite0, MemtoReg0, RegDst0, RegWrite0, ALUSrcA0;
  logic [1:0]  ALUSrcB0, PCSource0;
  logic [2:0]  ALUOp0;
  logic        illegal_op0;
  logic [3:0]  state0;
  logic [1:0]  instr_count0;

  logic [16:0] ctrl, ctrl0;
  assign ctrl  = {PCWrite, PCWriteCond, IorD, IRWrite, MemRead, MemWrite, MemtoReg, RegDst, RegWrite,
                  ALUSrcA, ALUSrcB, ALUOp, PCSource};
  assign ctrl0 = {PCWrite0, PCWriteCond0, IorD0, IRWrite0, MemRead0, MemWrite0, MemtoReg0, RegDst0, RegWrite0,
                  ALUSrcA0, ALUSrcB0, ALUOp0, PCSource0};

  mc_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .MEM_WAIT(1), .CNT_W(32)) dut (
    .clk(clk), .reset_n(reset_n), .opcode(opcode), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .IorD(IorD), .IRWrite(IRWrite),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .RegDst(RegDst),
    .RegWrite(RegWrite), .ALUSrcA(ALUSrcA), .ALUSrcB(ALUSrcB), .ALUOp(ALUOp),
    .PCSource(PCSource), .illegal_op(illegal_op), .state(state), .instr_count(instr_count)
  );

  mc_control_unit #(.OPCODE_W(6), .ALUOP_W(3), .MEM_WAIT(0), .CNT_W(2)) dut0 (
    .clk(clk), .reset_n(reset0_n), .opcode(opcode), .mem_ready(mem_ready0),
    .PCWrite(PCWrite0), .PCWriteCond(PCWriteCond0), .IorD(IorD0), .IRWrite(IRWrite0),
    .MemRead(MemRead0), .MemWrite(MemWrite0), .MemtoReg(MemtoReg0), .RegDst(RegDst0),
    .RegWrite(RegWrite0), .ALUSrcA(ALUSrcA0), .ALUSrcB(ALUSrcB0), .ALUOp(ALUOp0),
    .PCSource(PCSource0), .illegal_op(illegal_op0), .state(state0), .instr_count(instr_count0)
  );

  int          checks = 0;
  int          errors = 0;
  int          path[$];
  logic [31:0] cnt;
  logic        ill_pend;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Instruction classes from the opcode table: the sequence of steps each one walks through
  function automatic void build_path(input logic [5:0] op);
    path = {};
    path.push_back(F);
    path.push_back(D);
    case (op)
      6'b000000: begin path.push_back(RX); path.push_back(RW); end
      6'b100011: begin path.push_back(MA); path.push_back(MR); path.push_back(MWB); end
      6'b101011: begin path.push_back(MA); path.push_back(MWR); end
      6'b000100: path.push_back(BR);
      6'b000010: path.push_back(JP);
      6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010: begin
        path.push_back(IX); path.push_back(IW);
      end
      default: ;
    endcase
  endfunction

  function automatic logic [2:0] iop_of(input logic [5:0] op);
    case (op)
      6'b001100: return 3'b011;
      6'b001101: return 3'b100;
      6'b001110: return 3'b101;
      6'b001010: return 3'b110;
      default:   return 3'b000;
    endcase
  endfunction

  // Control word expected in each step, as listed in the step descriptions
  function automatic logic [16:0] exp_ctrl(input int st, input logic [2:0] iop, input logic rdy);
    logic pcw, pcwc, iord, irw, mr, mw, m2r, rdst, rw, asa;
    logic [1:0] asb, pcs;
    logic [2:0] aop;
    {pcw, pcwc, iord, irw, mr, mw, m2r, rdst, rw, asa} = '0;
    asb = 2'b00; pcs = 2'b00; aop = 3'b000;
    case (st)
      F:   begin mr = 1; asb = 2'b01; pcw = rdy; irw = rdy; end
      D:   asb = 2'b11;
      MA:  begin asa = 1; asb = 2'b10; end
      MR:  begin mr = 1; iord = 1; end
      MWB: begin rw = 1; m2r = 1; end
      MWR: begin mw = 1; iord = 1; end
      RX:  begin asa = 1; aop = 3'b010; end
      RW:  begin rw = 1; rdst = 1; end
      IX:  begin asa = 1; asb = 2'b10; aop = iop; end
      IW:  rw = 1;
      BR:  begin asa = 1; aop = 3'b001; pcwc = 1; pcs = 2'b01; end
      JP:  begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    return {pcw, pcwc, iord, irw, mr, mw, m2r, rdst, rw, asa, asb, aop, pcs};
  endfunction

  task automatic run_instr(input logic [5:0] op, input int wmin, input int wmax);
    int st, waits;
    logic is_mem;
    build_path(op);
    for (int k = 0; k < path.size(); k++) begin
      st = path[k];
      is_mem = (st == F) || (st == MR) || (st == MWR);
      waits = is_mem ? int'($urandom_range(wmax, wmin)) : 0;
      for (int w = 0; w <= waits; w++) begin
        @(negedge clk);
        mem_ready = is_mem ? (w == waits) : 1'($urandom);
        opcode = (st == D || st == MA) ? op : 6'($urandom);
        #1;
        chk("state", 32'(state), 32'(st));
        chk("ctrl", 32'(ctrl), 32'(exp_ctrl(st, iop_of(op), mem_ready)));
        chk("illegal_op", 32'(illegal_op), 32'(ill_pend));
        chk("instr_count", instr_count, cnt);
        ill_pend = 1'b0;
      end
    end
    if (path.size() == 2) ill_pend = 1'b1;
    else cnt = cnt + 1;
  endtask

  logic [5:0] legal [10];
  logic [5:0] op;

  initial begin
    legal = '{6'b000000, 6'b100011, 6'b101011, 6'b000100, 6'b000010,
              6'b001000, 6'b001100, 6'b001101, 6'b001110, 6'b001010};
    reset_n = 1'b0; reset0_n = 1'b0; mem_ready = 1'b0; mem_ready0 = 1'b0; opcode = '0;
    cnt = '0; ill_pend = 1'b0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_state", 32'(state), 32'(F));
    chk("rst_ctrl", 32'(ctrl), 32'(exp_ctrl(F, 3'b000, 1'b0)));
    chk("rst_count", instr_count, 32'd0);
    chk("rst_illegal", 32'(illegal_op), 32'd0);
    reset_n = 1'b1;

    // Directed flows: lw, sw with stalls, ori, beq then j, illegal opcode
    run_instr(6'b100011, 0, 0);
    run_instr(6'b101011, 3, 3);
    run_instr(6'b001101, 0, 0);
    run_instr(6'b000100, 0, 0);
    run_instr(6'b000010, 0, 0);
    run_instr(6'b111111, 0, 0);
    run_instr(6'b000000, 0, 2);

    // Randomized instruction stream with random stalls and occasional illegal opcodes
    for (int n = 0; n < 150; n++) begin
      if ($urandom_range(4, 0) == 0) op = 6'($urandom);
      else op = legal[$urandom_range(9, 0)];
      run_instr(op, 0, 3);
    end

    // Asynchronous reset while stalled in MEM_RD
    @(negedge clk); mem_ready = 1'b1; opcode = 6'b100011;
    @(negedge clk); #1; chk("lw_dec_state", 32'(state), 32'(D));
    @(negedge clk); mem_ready = 1'b0;
    @(negedge clk); #1; chk("lw_memrd_state", 32'(state), 32'(MR));
    #2 reset_n = 1'b0;
    #1;
    chk("arst_state", 32'(state), 32'(F));
    chk("arst_ctrl", 32'(ctrl), 32'(exp_ctrl(F, 3'b000, 1'b0)));
    chk("arst_count", instr_count, 32'd0);
    chk("arst_illegal", 32'(illegal_op), 32'd0);
    cnt = '0; ill_pend = 1'b0;
    @(negedge clk); reset_n = 1'b1;
    run_instr(6'b100011, 0, 1);
    run_instr(6'b001010, 0, 0);
    run_instr(6'b000000, 0, 0);

    // MEM_WAIT=0 instance: mem_ready held low, lw still 5 cycles, 2-bit counter wraps
    @(negedge clk); reset0_n = 1'b1; opcode = 6'b100011; mem_ready0 = 1'b0;
    for (int n = 0; n < 6; n++) begin
      build_path(6'b100011);
      for (int k = 0; k < path.size(); k++) begin
        #1;
        chk("nw_state", 32'(state0), 32'(path[k]));
        chk("nw_ctrl", 32'(ctrl0), 32'(exp_ctrl(path[k], 3'b000, 1'b1)));
        chk("nw_count", 32'(instr_count0), 32'(n % 4));
        chk("nw_illegal", 32'(illegal_op0), 32'd0);
        @(negedge clk);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
